// File: rtl/microsequencer_if.sv
// Control-word, handshake and status signals shared between the microsequencer
// and whatever drives its control store inputs.
interface microsequencer_if;
    logic [6:0] encoder_in;
    logic [2:0] ns_ctl;
    logic [6:0] cr_addr;
    logic       cond;
    logic       inv;
    logic       mfc;
    logic [6:0] state_out;
    logic       mf_wait;
    logic       fault;

    modport master (
        output encoder_in, ns_ctl, cr_addr, cond, inv, mfc,
        input  state_out, mf_wait, fault
    );

    modport slave (
        input  encoder_in, ns_ctl, cr_addr, cond, inv, mfc,
        output state_out, mf_wait, fault
    );
endinterface

// File: rtl/microsequencer.sv
// Next-state sequencer for a microcoded control unit: increment, dispatch, jump,
// conditional branch, memory-wait with timeout, return, and an absorbing fault state.
module microsequencer #(
    parameter logic [6:0] FETCH_STATE = 7'd1,
    parameter logic [6:0] FAULT_STATE = 7'd127,
    parameter logic [3:0] MFC_TIMEOUT = 4'd15
) (
    input  logic             clk,
    input  logic             reset,
    microsequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        NS_INC   = 3'b000,
        NS_DISP  = 3'b001,
        NS_JUMP  = 3'b010,
        NS_CBR   = 3'b011,
        NS_WAIT  = 3'b100,
        NS_RET   = 3'b101,
        NS_RSV0  = 3'b110,
        NS_RSV1  = 3'b111
    } ns_e;

    ns_e        op;
    logic [6:0] state_q, state_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic [6:0] state_inc;
    logic       in_fault;

    assign op        = ns_e'(bus.ns_ctl);
    assign state_inc = state_q + 7'd1;
    assign in_fault  = (state_q == FAULT_STATE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= 7'd0;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = 4'd0;
        if (!in_fault) begin
            case (op)
                NS_INC:  state_d = state_inc;
                NS_DISP: state_d = (bus.encoder_in == 7'd0) ? FETCH_STATE : bus.encoder_in;
                NS_JUMP: state_d = bus.cr_addr;
                NS_CBR:  state_d = (bus.cond ^ bus.inv) ? bus.cr_addr : state_inc;
                NS_WAIT: begin
                    // mfc wins over an expiring timeout on the same edge
                    if (bus.mfc) begin
                        state_d = state_inc;
                    end else if (wcnt_q == MFC_TIMEOUT) begin
                        state_d = FAULT_STATE;
                    end else begin
                        wcnt_d = wcnt_q + 4'd1;
                    end
                end
                NS_RET:  state_d = FETCH_STATE;
                default: state_d = FAULT_STATE;
            endcase
        end
    end

    assign bus.state_out = state_q;
    assign bus.fault     = in_fault;
    assign bus.mf_wait   = (op == NS_WAIT) && !bus.mfc && !in_fault;
endmodule

// File: tb/tb_microsequencer.sv
// Directed-vector bench for the microsequencer; expected values are checked by a
// scoreboard monitor that samples outputs on the falling clock edge.
module tb_microsequencer;
    logic clk;
    logic reset;
    microsequencer_if bus ();

    microsequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] ns;
        logic [6:0] enc;
        logic [6:0] cr;
        logic       cond;
        logic       inv;
        logic       mfc;
        logic [6:0] es;
        logic       emw;
        logic       ef;
    } vec_t;

    typedef struct {
        int         idx;
        logic [6:0] es;
        logic       emw;
        logic       ef;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    localparam logic [2:0] INC = 3'b000, DSP = 3'b001, JMP = 3'b010, CBR = 3'b011,
                           WTM = 3'b100, RET = 3'b101, R6 = 3'b110, R7 = 3'b111;

    // es/emw/ef: outputs expected while this vector is applied, before its edge
    task automatic add(input logic rst_n, input logic [2:0] ns, input logic [6:0] enc,
                       input logic [6:0] cr, input logic cond, input logic inv, input logic mfc,
                       input logic [6:0] es, input logic emw, input logic ef);
        vec_t v;
        v.rst_n = rst_n; v.ns = ns; v.enc = enc; v.cr = cr; v.cond = cond; v.inv = inv;
        v.mfc = mfc; v.es = es; v.emw = emw; v.ef = ef;
        vecs.push_back(v);
    endtask

    initial begin
        // reset then INC x3
        add(1, INC, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 2, 0, 0);
        // dispatch
        add(1, JMP, 0, 5, 0, 0, 0, 3, 0, 0);
        add(1, DSP, 7'b0101100, 0, 0, 0, 0, 5, 0, 0);
        add(1, JMP, 0, 5, 0, 0, 0, 44, 0, 0);
        add(1, DSP, 0, 0, 0, 0, 0, 5, 0, 0);
        // conditional branch, all cond/inv combinations
        add(1, JMP, 0, 10, 0, 0, 0, 1, 0, 0);
        add(1, CBR, 0, 40, 1, 0, 0, 10, 0, 0);
        add(1, JMP, 0, 10, 0, 0, 0, 40, 0, 0);
        add(1, CBR, 0, 40, 1, 1, 0, 10, 0, 0);
        add(1, CBR, 0, 40, 0, 1, 0, 11, 0, 0);
        add(1, CBR, 0, 40, 0, 0, 0, 40, 0, 0);
        // short memory wait
        add(1, JMP, 0, 20, 0, 0, 0, 41, 0, 0);
        for (int i = 0; i < 3; i++) add(1, WTM, 0, 0, 0, 0, 0, 20, 1, 0);
        add(1, WTM, 0, 0, 0, 0, 1, 20, 0, 0);
        add(1, RET, 0, 0, 0, 0, 0, 21, 0, 0);
        // timeout: 16th stalled edge faults
        add(1, INC, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 16; i++) add(1, WTM, 0, 0, 0, 0, 0, 2, 1, 0);
        add(1, INC, 0, 0, 0, 0, 0, 127, 0, 1);
        add(1, JMP, 0, 3, 0, 0, 0, 127, 0, 1);
        add(1, WTM, 0, 0, 0, 0, 0, 127, 0, 1);
        add(1, DSP, 44, 0, 0, 0, 0, 127, 0, 1);
        add(0, INC, 0, 0, 0, 0, 0, 127, 0, 1);
        add(1, INC, 0, 0, 0, 0, 0, 0, 0, 0);
        // mfc on the timeout edge wins
        add(1, JMP, 0, 50, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 15; i++) add(1, WTM, 0, 0, 0, 0, 0, 50, 1, 0);
        add(1, WTM, 0, 0, 0, 0, 1, 50, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 51, 0, 0);
        // reset mid-wait aborts without fault
        for (int i = 0; i < 3; i++) add(1, WTM, 0, 0, 0, 0, 0, 52, 1, 0);
        add(0, WTM, 0, 0, 0, 0, 0, 52, 1, 0);
        add(1, INC, 0, 0, 0, 0, 0, 0, 0, 0);
        // reserved selects and increment into fault
        add(1, JMP, 0, 30, 0, 0, 0, 1, 0, 0);
        add(1, R7, 0, 0, 0, 0, 0, 30, 0, 0);
        add(0, INC, 0, 0, 0, 0, 0, 127, 0, 1);
        add(1, R6, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, INC, 0, 0, 0, 0, 0, 127, 0, 1);
        add(1, JMP, 0, 126, 0, 0, 0, 0, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 126, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 127, 0, 1);

        reset = 1'b0;
        bus.ns_ctl = INC; bus.encoder_in = '0; bus.cr_addr = '0;
        bus.cond = 1'b0; bus.inv = 1'b0; bus.mfc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            exp_t e;
            reset          = vecs[i].rst_n;
            bus.ns_ctl     = vecs[i].ns;
            bus.encoder_in = vecs[i].enc;
            bus.cr_addr    = vecs[i].cr;
            bus.cond       = vecs[i].cond;
            bus.inv        = vecs[i].inv;
            bus.mfc        = vecs[i].mfc;
            e.idx = i; e.es = vecs[i].es; e.emw = vecs[i].emw; e.ef = vecs[i].ef;
            sb.push_back(e);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end
        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks += 3;
            if (bus.state_out !== e.es) begin
                failures++;
                $display("FAIL state v%0d: got %0d required %0d", e.idx, bus.state_out, e.es);
            end
            if (bus.mf_wait !== e.emw) begin
                failures++;
                $display("FAIL mf_wait v%0d: got %b required %b", e.idx, bus.mf_wait, e.emw);
            end
            if (bus.fault !== e.ef) begin
                failures++;
                $display("FAIL fault v%0d: got %b required %b", e.idx, bus.fault, e.ef);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: run did not finish, required completion");
            $fatal(1);
        end
    end
endmodule

// File: doc/microsequencer.md
MICROSEQUENCER -- requirements
Module: microsequencer

Interface
REQ-001 Parameter FETCH_STATE, default 7'd1: control state that begins an instruction fetch.
REQ-002 Parameter FAULT_STATE, default 7'd127: sink state entered on sequencing errors.
REQ-003 Parameter MFC_TIMEOUT, default 4'd15: maximum hold cycles while waiting for memory-function-complete.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-006 encoder_in  input  7  dispatch state number from the instruction encoder.
REQ-007 ns_ctl  input  3  next-state select from the current control word.
REQ-008 cr_addr  input  7  explicit jump target from the current control word.
REQ-009 cond  input  1  condition-code test result.
REQ-010 inv  input  1  inverts cond for conditional branch.
REQ-011 mfc  input  1  memory-function-complete handshake from memory.
REQ-012 state_out  output  7  registered current control state.
REQ-013 mf_wait  output  1  high while stalled waiting for mfc.
REQ-014 fault  output  1  high whenever state_out == FAULT_STATE.

Function
REQ-015 state_out SHALL be a 7-bit register updated only on rising clk edges.
REQ-016 ns_ctl=000 (INC): next state = state_out+1, modulo 128.
REQ-017 ns_ctl=001 (DISPATCH): next state = encoder_in; if encoder_in == 0, next state = FETCH_STATE (NOP).
REQ-018 ns_ctl=010 (JUMP): next state = cr_addr.
REQ-019 ns_ctl=011 (CBR): if (cond XOR inv)==1, next = cr_addr; else next = state_out+1.
REQ-020 ns_ctl=100 (WAITMFC): if mfc=1, next = state_out+1 and the wait counter clears; else state holds and the 4-bit wait counter increments.
REQ-021 WAITMFC with mfc=0 and wait counter == MFC_TIMEOUT: next = FAULT_STATE, and the counter clears.
REQ-022 ns_ctl=101 (RETURN): next = FETCH_STATE.
REQ-023 ns_ctl=110/111 (reserved): next = FAULT_STATE.
REQ-024 The wait counter SHALL clear on every cycle in which ns_ctl != 100.
REQ-025 mf_wait SHALL be combinational: (ns_ctl==100) AND (mfc==0) AND (state_out != FAULT_STATE).
REQ-026 FAULT_STATE SHALL be absorbing: once entered, state_out holds regardless of ns_ctl, mfc, or encoder_in until reset.
REQ-027 Increment from 126 SHALL land in 127 (FAULT_STATE at default) and assert fault the next cycle.
REQ-028 fault SHALL be combinational from state_out; no other fault sources exist.
REQ-029 Latency: every transition takes exactly one clk cycle from input sampling to the state_out update.
REQ-030 mfc arriving on the same edge as the timeout count SHALL take priority: increment, no fault.

Reset
REQ-031 With reset=0 at a rising edge, state_out SHALL become 7'd0 and the wait counter SHALL become 0, overriding all other inputs, including FAULT_STATE.
REQ-032 After reset: fault=0; mf_wait follows REQ-025.
REQ-033 State 0 SHALL carry no special behaviour beyond ns_ctl decoding; the control word for state 0 is expected to select INC into FETCH_STATE.
REQ-034 Reset asserted mid-WAITMFC SHALL abort the wait, with no fault.

Verification
REQ-035 Reset, then INC ×3 -> state_out 0,1,2,3; fault=0.
REQ-036 From state 5: DISPATCH with encoder_in=7'b0101100 -> 44; DISPATCH with encoder_in=0 -> 1.
REQ-037 From state 10: CBR cr_addr=40, cond=1, inv=0 -> 40; cond=1, inv=1 -> 11.
REQ-038 From state 20: WAITMFC, mfc=0 for 3 cycles, then 1 -> state holds at 20 with mf_wait=1 for 3 cycles, then 21.
REQ-039 WAITMFC with mfc held 0 -> 16th edge enters 127 and fault=1; further INC/JUMP hold at 127; reset -> 0.
REQ-040 Reserved ns_ctl=111 from state 30 -> 127; increment from 126 -> 127, fault=1.
